cpu_bus_responder: RTL and testbench

Memory-side responder for the CPU core's bus operations. It sequences each M-cycle into four T-cycles, services the `bus_opcode_t` request (IDLE, IF, WRITE, READ, IF_CB) against a byte-wide memory port, and returns the read data, fetched opcode and CB-prefix flag to the core. It sits between the CPU datapath/control and the memory map decoder, and it generates the M-cycle tick that paces the core's control FSM.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_bus_responder.sv | 69 ++++++
 tb/tb_cpu_bus_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared bus opcode, T-cycle phase and timing constants for the CPU core
package cpu_pkg;
    typedef enum logic [2:0] {
        BUS_IDLE  = 3'd0,
        BUS_IF    = 3'd1,
        BUS_WRITE = 3'd2,
        BUS_READ  = 3'd3,
        BUS_IF_CB = 3'd4
    } bus_opcode_t;
    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } t_phase_t;
    localparam int T_PER_M = 4;
endpackage

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: sequences M-cycles into T-cycles and services bus requests on a byte-wide memory port
module cpu_bus_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  bus_opcode_t       bus_op,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              m_tick,
    output logic [1:0]        t_phase,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ir,
    output logic              cb_prefix,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    t_phase_t          phase;
    bus_opcode_t       op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              stall;
    logic              rd_op;
    logic              cap;
    assign rd_op     = (op_q == BUS_READ) || (op_q == BUS_IF) || (op_q == BUS_IF_CB);
    assign stall     = (phase == T3) && (op_q != BUS_IDLE) && !mem_ready;
    assign cap       = (phase == T3) && !stall;
    assign m_tick    = (phase == T4);
    assign t_phase   = phase;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_op && (phase != T4);
    assign mem_wr    = (op_q == BUS_WRITE) && ((phase == T2) || (phase == T3));
    // Phase counter with T3 wait states, and request capture at the end of each M-cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= T4;
            op_q    <= BUS_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            phase <= stall ? phase : t_phase_t'(phase + 2'd1);
            if (m_tick) begin
                op_q    <= (bus_op > BUS_IF_CB) ? BUS_IDLE : bus_op;
                addr_q  <= bus_addr;
                wdata_q <= bus_wdata;
            end
        end
    end
    // Return read data, opcode byte and CB flag on the edge leaving T3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= '0;
            ir        <= '0;
            cb_prefix <= 1'b0;
        end else begin
            rdata     <= (cap && op_q == BUS_READ) ? mem_rdata : rdata;
            ir        <= (cap && (op_q == BUS_IF || op_q == BUS_IF_CB)) ? mem_rdata : ir;
            cb_prefix <= (cap && op_q == BUS_IF) ? 1'b0 : (cap && op_q == BUS_IF_CB) ? 1'b1 : cb_prefix;
        end
    end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: randomized M-cycle stimulus checked against a per-transaction reference model
module tb_cpu_bus_responder;
    import cpu_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    bus_opcode_t bus_op;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        m_tick;
    logic [1:0]  t_phase;
    logic [7:0]  rdata, ir;
    logic        cb_prefix;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rdata_m, ir_m;
    logic       cb_m;

    cpu_bus_responder #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .bus_op(bus_op), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .m_tick(m_tick), .t_phase(t_phase), .rdata(rdata), .ir(ir), .cb_prefix(cb_prefix),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // One M-cycle: called during T4 of the previous M-cycle; ends at the negedge of its own T4.
    task automatic run_mcycle(input string tag, input logic [2:0] op, input logic [15:0] addr,
                              input logic [7:0] wd, input logic [7:0] data, input int waits);
        bit active, is_rd, is_wr;
        int n, t3_seen;
        logic [1:0] exp_ph;
        active = (op >= 3'd1) && (op <= 3'd4);
        is_rd  = (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
        is_wr  = (op == 3'd2);
        n      = T_PER_M + (active ? waits : 0);
        if (op == 3'd3) rdata_m = data;
        if (op == 3'd1) begin ir_m = data; cb_m = 1'b0; end
        if (op == 3'd4) begin ir_m = data; cb_m = 1'b1; end
        bus_op    = bus_opcode_t'(op);
        bus_addr  = addr;
        bus_wdata = wd;
        t3_seen   = 0;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_ph    = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : (i == n - 1) ? 2'd3 : 2'd2;
            mem_rdata = 8'($urandom);
            mem_ready = 1'($urandom);
            if (exp_ph == 2'd2) begin
                mem_ready = active ? (t3_seen >= waits) : 1'b0;
                if (mem_ready) mem_rdata = data;
                t3_seen++;
            end
            bus_op    = bus_opcode_t'(3'($urandom));
            bus_addr  = 16'($urandom);
            bus_wdata = 8'($urandom);
            n_cmp++;
            if (t_phase !== exp_ph) begin n_err++; $display("FAIL %s c%0d t_phase got %0d exp %0d", tag, i, t_phase, exp_ph); end
            n_cmp++;
            if (m_tick !== (i == n - 1)) begin n_err++; $display("FAIL %s c%0d m_tick got %b exp %b", tag, i, m_tick, i == n - 1); end
            n_cmp++;
            if (mem_rd !== (is_rd && i < n - 1)) begin n_err++; $display("FAIL %s c%0d mem_rd got %b exp %b", tag, i, mem_rd, is_rd && i < n - 1); end
            n_cmp++;
            if (mem_wr !== (is_wr && i >= 1 && i < n - 1)) begin n_err++; $display("FAIL %s c%0d mem_wr got %b exp %b", tag, i, mem_wr, is_wr && i >= 1 && i < n - 1); end
            n_cmp++;
            if (mem_addr !== addr || mem_wdata !== wd) begin n_err++; $display("FAIL %s c%0d addr/wdata got %h/%h exp %h/%h", tag, i, mem_addr, mem_wdata, addr, wd); end
        end
        bus_op    = bus_opcode_t'(3'($urandom));
        n_cmp++;
        if (rdata !== rdata_m) begin n_err++; $display("FAIL %s rdata got %h exp %h", tag, rdata, rdata_m); end
        n_cmp++;
        if (ir !== ir_m || cb_prefix !== cb_m) begin n_err++; $display("FAIL %s ir/cb got %h/%b exp %h/%b", tag, ir, cb_prefix, ir_m, cb_m); end
    endtask

    task automatic check_reset_state(input string tag);
        n_cmp++;
        if (t_phase !== 2'd3 || m_tick !== 1'b1) begin n_err++; $display("FAIL %s phase/tick got %0d/%b exp 3/1", tag, t_phase, m_tick); end
        n_cmp++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL %s strobes got %b%b exp 00", tag, mem_rd, mem_wr); end
        n_cmp++;
        if (mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin n_err++; $display("FAIL %s addr/wdata got %h/%h exp 0/0", tag, mem_addr, mem_wdata); end
        n_cmp++;
        if (rdata !== 8'h0 || ir !== 8'h0 || cb_prefix !== 1'b0) begin n_err++; $display("FAIL %s data got %h/%h/%b exp 0/0/0", tag, rdata, ir, cb_prefix); end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus_op = BUS_READ; bus_addr = 16'hC000; bus_wdata = 8'h00;
        mem_rdata = 8'h5A; mem_ready = 1'b1;
        rdata_m = 8'h0; ir_m = 8'h0; cb_m = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
    endtask

    task automatic test_read;
        run_mcycle("read", 3'd3, 16'hC000, 8'h00, 8'h5A, 0);
        run_mcycle("read2", 3'd3, 16'hC001, 8'h11, 8'hE7, 0);
    endtask

    task automatic test_if_cb;
        run_mcycle("if", 3'd1, 16'h0100, 8'h00, 8'hCB, 0);
        run_mcycle("if_cb", 3'd4, 16'h0101, 8'h00, 8'h37, 0);
    endtask

    task automatic test_write;
        run_mcycle("write", 3'd2, 16'hFF80, 8'hA5, 8'h99, 0);
        run_mcycle("write_wait", 3'd2, 16'hFF81, 8'h3C, 8'h99, 2);
    endtask

    task automatic test_wait_states;
        run_mcycle("wait_read", 3'd3, 16'h8000, 8'h00, 8'h6D, 3);
    endtask

    task automatic test_reset_mid_access;
        bus_op = BUS_WRITE; bus_addr = 16'h1234; bus_wdata = 8'h77;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (t_phase !== 2'd1 || mem_wr !== 1'b1) begin n_err++; $display("FAIL midrst pre phase/wr got %0d/%b exp 1/1", t_phase, mem_wr); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_wr !== 1'b0) begin n_err++; $display("FAIL midrst async mem_wr got %b exp 0", mem_wr); end
        rdata_m = 8'h0; ir_m = 8'h0; cb_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
    endtask

    task automatic test_illegal;
        run_mcycle("illegal6", 3'd6, 16'h4000, 8'h12, 8'hFF, 3);
        run_mcycle("idle", 3'd0, 16'h4001, 8'h34, 8'hFF, 2);
    endtask

    task automatic test_random;
        for (int k = 0; k < 300; k++)
            run_mcycle("rand", 3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        test_reset;
        test_read;
        test_if_cb;
        test_write;
        test_wait_states;
        test_illegal;
        test_reset_mid_access;
        test_read;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
